// File: rtl/uart_tx_frame_ctrl_if.sv
// Frame-request, serializer and line signals of uart_tx_frame_ctrl.
// master = host plus serializer side, slave = the frame controller.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  BUSY;
  logic                  TX_OUT;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, BUSY, TX_OUT
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, BUSY, TX_OUT
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: START, DATA (external serializer), optional PARITY, STOP.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_frame_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [DATA_WIDTH-1:0] data_lat;
  logic                  accept;

  // A new frame is taken from IDLE or back-to-back from the STOP cycle.
  assign accept = bus.DATA_VALID && ((state == IDLE) || (state == STOP));

`ifdef UART_TX_PARITY_EN
  logic par_en_lat;
  logic par_typ_lat;
  logic par_bit;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                      input logic                  odd);
    return (^d) ^ odd;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
    end else if (accept) begin
      par_en_lat  <= bus.PAR_EN;
      par_typ_lat <= bus.PAR_TYP;
    end
  end

  assign par_bit = parity_bit(data_lat, par_typ_lat);
`else
  // Without parity the latched data and parity controls have no consumer.
  logic unused_nopar;
  assign unused_nopar = ^{data_lat, bus.PAR_EN, bus.PAR_TYP};
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.DATA_VALID) state_nxt = START;
      START: state_nxt = DATA;
      DATA: begin
        if (bus.ser_done) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en_lat ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_nxt = STOP;
`endif
      STOP:    state_nxt = bus.DATA_VALID ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      data_lat <= '0;
    end else begin
      state <= state_nxt;
      if (accept) data_lat <= bus.P_DATA;
    end
  end

  // Status outputs depend on the state register alone.
  assign bus.BUSY   = (state != IDLE);
  assign bus.ser_en = (state == DATA);

  always_comb begin
    bus.TX_OUT = 1'b1;
    unique case (state)
      START:  bus.TX_OUT = 1'b0;
      DATA:   bus.TX_OUT = bus.ser_data;
`ifdef UART_TX_PARITY_EN
      PARITY: bus.TX_OUT = par_bit;
`endif
      default: bus.TX_OUT = 1'b1;
    endcase
  end

endmodule
